reg_wb: RTL and testbench
=========================

REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 Parameter IO_TIMEOUT, default 15, SHALL be the number of IO_WAIT cycles without IO_ACK before abort (range 1..15).
REQ-002 CLK_WB  in  1  sole clock, rising edge.
REQ-003 RST_WB  in  1  reset, synchronous, active-high.
REQ-004 WB_VALID  in  1  write-back request valid.
REQ-005 WB_READY  out  1  unit can accept a request this cycle.
REQ-006 REG_O_TYPE  in  2  destination type: 00 general reg, 01 IO reg, 10 discard, 11 illegal.
REQ-007 REG_O_ADDR  in  4  destination index.
REQ-008 RESULT  in  8  data to write.
REQ-009 IO_ACK  in  1  IO side has consumed the strobed byte.
REQ-010 IO_STB  out  1  IO byte update pending.
REQ-011 IO_ADDR  out  3  index of pending IO byte.
REQ-012 ERR_CLR  in  1  clears ERR.
REQ-013 REG_R  out  128  16 x 8-bit general registers, reg n at bits [8n+7:8n].
REQ-014 REG_IO  out  64  8 x 8-bit IO registers, reg n at bits [8n+7:8n].
REQ-015 ERR  out  2  sticky: bit0 IO timeout, bit1 illegal type.

Function
REQ-016 States SHALL be IDLE and IO_WAIT; WB_READY SHALL be 1 exactly in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where WB_VALID and WB_READY are both 1; otherwise inputs are ignored.
REQ-018 Type 00 accept SHALL write RESULT to REG_R byte REG_O_ADDR, visible the cycle after accept; state stays IDLE (one write per cycle, back-to-back allowed).
REQ-019 Type 01 accept SHALL write RESULT to REG_IO byte REG_O_ADDR[2:0] (bit 3 ignored), latch IO_ADDR, set IO_STB, and enter IO_WAIT, all visible the cycle after accept.
REQ-020 In IO_WAIT, IO_ACK sampled 1 SHALL clear IO_STB and return to IDLE on that edge.
REQ-021 In IO_WAIT a 4-bit counter SHALL count sampled cycles with IO_ACK=0; at IO_TIMEOUT such cycles it SHALL set ERR[0], clear IO_STB, return to IDLE; REG_IO keeps the written byte.
REQ-022 IO_ACK arriving on the same edge the timeout is reached SHALL count as acknowledge; ERR[0] is not set.
REQ-023 IO_ACK while IDLE SHALL be ignored.
REQ-024 Type 10 accept SHALL perform no write and stay IDLE.
REQ-025 Type 11 accept SHALL perform no write, set ERR[1], stay IDLE.
REQ-026 ERR bits SHALL stay set until ERR_CLR=1; set and clear on the same edge SHALL leave the bit set.
REQ-027 REG_R/REG_IO SHALL change only through REQ-018/REQ-019; all outputs are registered.

Reset
REQ-028 RST_WB=1 on an edge SHALL force IDLE, counter 0, IO_STB 0, IO_ADDR 0, ERR 0, REG_R 0, REG_IO 0, WB_READY 1 the following cycle.
REQ-029 Reset SHALL take priority over any request, IO_ACK or ERR_CLR on the same edge, including mid-IO_WAIT.

Configuration
REQ-030 With REG_WB_R0_ZERO_EN defined, REG_R byte 0 SHALL read constant 0 and type 00 writes to address 0 SHALL be accepted and discarded; without it register 0 is writable like any other.

Structure
REQ-031 A shared package SHALL hold the REG_O_TYPE encodings, state encoding, ERR bit indices and register/IO counts (16, 8).
REQ-032 One sub-module reg_wb_io_hs SHALL contain the IO_WAIT state, timeout counter, IO_STB/IO_ADDR; storage and decode stay in reg_wb.

Verification
REQ-033 Reset, then type 00 addr 5 RESULT 8'hA7 -> REG_R[47:40]=8'hA7 next cycle, all other bytes 0, WB_READY 1.
REQ-034 Type 01 addr 4'hB RESULT 8'h3C, IO_ACK on 3rd cycle -> REG_IO[31:24]=8'h3C, IO_ADDR 3, IO_STB 1 for 3 cycles, WB_READY 0 meanwhile, then IDLE, ERR 0.
REQ-035 Type 01 addr 2 with IO_ACK held 0 -> IO_STB drops after 15 cycles, ERR=2'b01, REG_IO[23:16] retains value; ERR_CLR -> ERR 0.
REQ-036 Type 11 then type 10 back-to-back -> no register change, ERR=2'b10, WB_READY stays 1.
REQ-037 RST_WB asserted 2 cycles into IO_WAIT with WB_VALID=1 -> next cycle IDLE, IO_STB 0, REG_IO all 0, request not accepted.
REQ-038 With REG_WB_R0_ZERO_EN defined, type 00 addr 0 RESULT 8'hFF -> REG_R[7:0] stays 0; undefined -> 8'hFF.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared definitions for the reg_wb write-back unit: destination type encodings,
// handshake state encoding, ERR bit positions and register-file sizes.
package reg_wb_pkg;

  localparam int NUM_GEN_REGS = 16;
  localparam int NUM_IO_REGS  = 8;

  typedef enum logic [1:0] {
    TYPE_GEN     = 2'b00,
    TYPE_IO      = 2'b01,
    TYPE_DISCARD = 2'b10,
    TYPE_ILLEGAL = 2'b11
  } reg_o_type_e;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_IO_WAIT = 1'b1;

  localparam int ERR_IO_TIMEOUT = 0;
  localparam int ERR_ILLEGAL    = 1;

  // Sticky error update: a set arriving together with a clear wins.
  function automatic logic [1:0] err_next(input logic [1:0] cur,
                                          input logic [1:0] set,
                                          input logic       clr);
    return (clr ? 2'b00 : cur) | set;
  endfunction

endpackage

// File: rtl/reg_wb_io_hs.sv
// IO byte handshake: holds IO_STB/IO_ADDR after an IO write and waits for IO_ACK,
// aborting after IO_TIMEOUT unacknowledged cycles.
module reg_wb_io_hs
  import reg_wb_pkg::*;
#(
  parameter int IO_TIMEOUT = 15
) (
  input  logic       CLK_WB,
  input  logic       RST_WB,
  input  logic       start,
  input  logic [2:0] start_addr,
  input  logic       IO_ACK,
  output logic       ready,
  output logic       IO_STB,
  output logic [2:0] IO_ADDR,
  output logic       timeout
);

  localparam logic [3:0] LAST_CNT = 4'(IO_TIMEOUT - 1);

  logic [0:0] state_q;
  logic [3:0] cnt_q;

  assign ready = (state_q == ST_IDLE);

  // An acknowledge on the expiring edge takes precedence over the abort.
  assign timeout = (state_q == ST_IO_WAIT) && !IO_ACK && (cnt_q == LAST_CNT);

  always_ff @(posedge CLK_WB) begin
    if (RST_WB) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      IO_STB  <= 1'b0;
      IO_ADDR <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_IO_WAIT;
            cnt_q   <= '0;
            IO_STB  <= 1'b1;
            IO_ADDR <= start_addr;
          end
        end
        ST_IO_WAIT: begin
          if (IO_ACK || timeout) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            IO_STB  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          IO_STB  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_wb.sv
// Write-back unit: decodes a destination type and writes RESULT into the general or IO
// register file, with sticky error flags. Define REG_WB_R0_ZERO_EN to hard-wire REG_R byte 0 to zero.
module reg_wb
  import reg_wb_pkg::*;
#(
  parameter int IO_TIMEOUT = 15
) (
  input  logic         CLK_WB,
  input  logic         RST_WB,
  input  logic         WB_VALID,
  output logic         WB_READY,
  input  logic [1:0]   REG_O_TYPE,
  input  logic [3:0]   REG_O_ADDR,
  input  logic [7:0]   RESULT,
  input  logic         IO_ACK,
  output logic         IO_STB,
  output logic [2:0]   IO_ADDR,
  input  logic         ERR_CLR,
  output logic [127:0] REG_R,
  output logic [63:0]  REG_IO,
  output logic [1:0]   ERR
);

  logic [NUM_GEN_REGS-1:0][7:0] reg_r_q;
  logic [NUM_IO_REGS-1:0][7:0]  reg_io_q;
  logic [1:0]                   err_q;

  reg_o_type_e wb_type;
  logic        accept;
  logic        gen_we;
  logic        io_we;
  logic        illegal;
  logic        io_timeout;
  logic        hs_ready;

  assign wb_type = reg_o_type_e'(REG_O_TYPE);
  assign accept  = WB_VALID && WB_READY;

`ifdef REG_WB_R0_ZERO_EN
  // Register 0 is never written, so its reset value of zero is what reads back.
  assign gen_we = accept && (wb_type == TYPE_GEN) && (REG_O_ADDR != 4'd0);
`else
  assign gen_we = accept && (wb_type == TYPE_GEN);
`endif

  assign io_we   = accept && (wb_type == TYPE_IO);
  assign illegal = accept && (wb_type == TYPE_ILLEGAL);

  reg_wb_io_hs #(
    .IO_TIMEOUT (IO_TIMEOUT)
  ) u_io_hs (
    .CLK_WB     (CLK_WB),
    .RST_WB     (RST_WB),
    .start      (io_we),
    .start_addr (REG_O_ADDR[2:0]),
    .IO_ACK     (IO_ACK),
    .ready      (hs_ready),
    .IO_STB     (IO_STB),
    .IO_ADDR    (IO_ADDR),
    .timeout    (io_timeout)
  );

  assign WB_READY = hs_ready;

  // NOTE: the register files are plain flops that must read zero after reset, so they are
  // reset explicitly; this is why they cannot be mapped onto a RAM macro.
  always_ff @(posedge CLK_WB) begin
    if (RST_WB) begin
      reg_r_q  <= '0;
      reg_io_q <= '0;
    end else begin
      if (gen_we) reg_r_q[REG_O_ADDR]       <= RESULT;
      if (io_we)  reg_io_q[REG_O_ADDR[2:0]] <= RESULT;
    end
  end

  always_ff @(posedge CLK_WB) begin
    if (RST_WB) begin
      err_q <= '0;
    end else begin
      err_q <= err_next(err_q, {illegal, io_timeout}, ERR_CLR);
    end
  end

  assign REG_R  = reg_r_q;
  assign REG_IO = reg_io_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_reg_wb.sv
// Self-checking bench for reg_wb: directed scenarios plus randomized transactions
// checked against a transaction-level model of the register files and error flags.
module tb_reg_wb;

  logic         CLK_WB;
  logic         RST_WB;
  logic         WB_VALID;
  logic         WB_READY;
  logic [1:0]   REG_O_TYPE;
  logic [3:0]   REG_O_ADDR;
  logic [7:0]   RESULT;
  logic         IO_ACK;
  logic         IO_STB;
  logic [2:0]   IO_ADDR;
  logic         ERR_CLR;
  logic [127:0] REG_R;
  logic [63:0]  REG_IO;
  logic [1:0]   ERR;

  int n_cmp = 0;
  int n_mis = 0;

  localparam int TIMEOUT = 15;

  // Reference model
  logic [7:0] mr  [16];
  logic [7:0] mio [8];
  logic [1:0] merr;

  reg_wb #(.IO_TIMEOUT(TIMEOUT)) dut (
    .CLK_WB     (CLK_WB),
    .RST_WB     (RST_WB),
    .WB_VALID   (WB_VALID),
    .WB_READY   (WB_READY),
    .REG_O_TYPE (REG_O_TYPE),
    .REG_O_ADDR (REG_O_ADDR),
    .RESULT     (RESULT),
    .IO_ACK     (IO_ACK),
    .IO_STB     (IO_STB),
    .IO_ADDR    (IO_ADDR),
    .ERR_CLR    (ERR_CLR),
    .REG_R      (REG_R),
    .REG_IO     (REG_IO),
    .ERR        (ERR)
  );

  initial CLK_WB = 1'b0;
  always #5 CLK_WB = ~CLK_WB;

  function automatic logic [127:0] pack_r();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = mr[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_io();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mio[i];
    return v;
  endfunction

  function automatic bit r0_writable();
`ifdef REG_WB_R0_ZERO_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Applies a request as seen by the model when it is accepted.
  task automatic model_accept(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d);
    case (t)
      2'b00: if (a != 0 || r0_writable()) mr[a] = d;
      2'b01: mio[a % 8] = d;
      2'b11: merr[1] = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mr[i] = 8'h00;
    for (int i = 0; i < 8; i++) mio[i] = 8'h00;
    merr = 2'b00;
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK_WB);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d);
    WB_VALID   = 1'b1;
    REG_O_TYPE = t;
    REG_O_ADDR = a;
    RESULT     = d;
    step();
  endtask

  task automatic test_reset();
    RST_WB = 1'b1;
    step();
    step();
    RST_WB = 1'b0;
    model_clear();
    n_cmp++; if (WB_READY !== 1'b1) begin n_mis++; $display("FAIL reset_ready got %b want 1", WB_READY); end
    n_cmp++; if (IO_STB !== 1'b0) begin n_mis++; $display("FAIL reset_stb got %b want 0", IO_STB); end
    n_cmp++; if (IO_ADDR !== 3'd0) begin n_mis++; $display("FAIL reset_io_addr got %0d want 0", IO_ADDR); end
    n_cmp++; if (ERR !== 2'b00) begin n_mis++; $display("FAIL reset_err got %b want 00", ERR); end
    n_cmp++; if (REG_R !== 128'h0) begin n_mis++; $display("FAIL reset_reg_r got %h want 0", REG_R); end
    n_cmp++; if (REG_IO !== 64'h0) begin n_mis++; $display("FAIL reset_reg_io got %h want 0", REG_IO); end
  endtask

  task automatic test_gen_write();
    logic [127:0] exp;
    exp = '0;
    exp[47:40] = 8'hA7;
    drive_req(2'b00, 4'd5, 8'hA7);
    WB_VALID = 1'b0;
    model_accept(2'b00, 4'd5, 8'hA7);
    n_cmp++; if (REG_R !== exp) begin n_mis++; $display("FAIL gen_write reg_r got %h want %h", REG_R, exp); end
    n_cmp++; if (WB_READY !== 1'b1) begin n_mis++; $display("FAIL gen_write ready got %b want 1", WB_READY); end
  endtask

  task automatic test_io_ack();
    drive_req(2'b01, 4'hB, 8'h3C);
    WB_VALID = 1'b0;
    model_accept(2'b01, 4'hB, 8'h3C);
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (IO_STB !== 1'b1 || WB_READY !== 1'b0 || IO_ADDR !== 3'd3) begin
        n_mis++; $display("FAIL io_ack_wait cycle %0d got stb=%b ready=%b addr=%0d want 1 0 3", c, IO_STB, WB_READY, IO_ADDR);
      end
      if (c == 3) IO_ACK = 1'b1;
      step();
      IO_ACK = 1'b0;
    end
    n_cmp++; if (IO_STB !== 1'b0 || WB_READY !== 1'b1) begin
      n_mis++; $display("FAIL io_ack_done got stb=%b ready=%b want 0 1", IO_STB, WB_READY);
    end
    n_cmp++; if (REG_IO[31:24] !== 8'h3C || ERR !== 2'b00) begin
      n_mis++; $display("FAIL io_ack_data got io=%h err=%b want 3c 00", REG_IO[31:24], ERR);
    end
  endtask

  task automatic test_io_timeout();
    drive_req(2'b01, 4'd2, 8'h5A);
    WB_VALID = 1'b0;
    model_accept(2'b01, 4'd2, 8'h5A);
    for (int c = 1; c <= TIMEOUT; c++) begin
      n_cmp++; if (IO_STB !== 1'b1 || ERR !== 2'b00) begin
        n_mis++; $display("FAIL io_timeout_wait cycle %0d got stb=%b err=%b want 1 00", c, IO_STB, ERR);
      end
      step();
    end
    merr[0] = 1'b1;
    n_cmp++; if (IO_STB !== 1'b0 || WB_READY !== 1'b1 || ERR !== 2'b01) begin
      n_mis++; $display("FAIL io_timeout_done got stb=%b ready=%b err=%b want 0 1 01", IO_STB, WB_READY, ERR);
    end
    n_cmp++; if (REG_IO[23:16] !== 8'h5A) begin n_mis++; $display("FAIL io_timeout_data got %h want 5a", REG_IO[23:16]); end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    merr = 2'b00;
    n_cmp++; if (ERR !== 2'b00) begin n_mis++; $display("FAIL err_clr got %b want 00", ERR); end
  endtask

  task automatic test_illegal_discard();
    logic [127:0] r_before;
    logic [63:0]  io_before;
    r_before  = pack_r();
    io_before = pack_io();
    drive_req(2'b11, 4'd7, 8'h11);
    model_accept(2'b11, 4'd7, 8'h11);
    n_cmp++; if (WB_READY !== 1'b1 || ERR !== 2'b10) begin
      n_mis++; $display("FAIL illegal got ready=%b err=%b want 1 10", WB_READY, ERR);
    end
    drive_req(2'b10, 4'd9, 8'h22);
    WB_VALID = 1'b0;
    n_cmp++; if (REG_R !== r_before || REG_IO !== io_before) begin
      n_mis++; $display("FAIL discard regs got r=%h io=%h want r=%h io=%h", REG_R, REG_IO, r_before, io_before);
    end
    n_cmp++; if (WB_READY !== 1'b1 || ERR !== 2'b10) begin
      n_mis++; $display("FAIL discard got ready=%b err=%b want 1 10", WB_READY, ERR);
    end
    // Clear and set on the same edge: the bit must remain set
    ERR_CLR = 1'b1;
    drive_req(2'b11, 4'd0, 8'h00);
    WB_VALID = 1'b0;
    ERR_CLR  = 1'b0;
    n_cmp++; if (ERR !== 2'b10) begin n_mis++; $display("FAIL err_set_clr got %b want 10", ERR); end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    merr = 2'b00;
    n_cmp++; if (ERR !== 2'b00) begin n_mis++; $display("FAIL err_clr2 got %b want 00", ERR); end
  endtask

  task automatic test_reset_mid_wait();
    drive_req(2'b01, 4'd6, 8'h99);
    WB_VALID = 1'b0;
    step();
    step();
    RST_WB = 1'b1;
    IO_ACK = 1'b1;
    ERR_CLR = 1'b1;
    drive_req(2'b00, 4'd3, 8'h44);
    WB_VALID = 1'b0;
    RST_WB   = 1'b0;
    IO_ACK   = 1'b0;
    ERR_CLR  = 1'b0;
    model_clear();
    n_cmp++; if (WB_READY !== 1'b1 || IO_STB !== 1'b0 || IO_ADDR !== 3'd0) begin
      n_mis++; $display("FAIL rst_mid_wait got ready=%b stb=%b addr=%0d want 1 0 0", WB_READY, IO_STB, IO_ADDR);
    end
    n_cmp++; if (REG_IO !== 64'h0 || REG_R !== 128'h0) begin
      n_mis++; $display("FAIL rst_mid_wait regs got r=%h io=%h want 0", REG_R, REG_IO);
    end
  endtask

  task automatic test_r0();
    logic [7:0] exp;
    exp = r0_writable() ? 8'hFF : 8'h00;
    drive_req(2'b00, 4'd0, 8'hFF);
    WB_VALID = 1'b0;
    model_accept(2'b00, 4'd0, 8'hFF);
    n_cmp++; if (REG_R[7:0] !== exp) begin n_mis++; $display("FAIL r0 got %h want %h", REG_R[7:0], exp); end
  endtask

  // Random transactions; IO writes get a random acknowledge delay that may exceed the timeout.
  task automatic test_random();
    logic [1:0] t;
    logic [3:0] a;
    logic [7:0] d;
    logic       clr;
    int         k;
    int         stb_cycles;
    for (int n = 0; n < 60; n++) begin
      t   = 2'($urandom_range(0, 3));
      a   = 4'($urandom);
      d   = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      ERR_CLR = clr;
      IO_ACK  = 1'($urandom);
      if (clr) merr = 2'b00;
      drive_req(t, a, d);
      ERR_CLR = 1'b0;
      IO_ACK  = 1'b0;
      model_accept(t, a, d);
      if (t == 2'b01) begin
        k = $urandom_range(1, TIMEOUT + 3);
        stb_cycles = 0;
        for (int c = 1; c <= TIMEOUT; c++) begin
          if (IO_STB === 1'b1 && WB_READY === 1'b0 && IO_ADDR === a[2:0]) stb_cycles++;
          // Requests while busy must be ignored
          WB_VALID   = 1'($urandom);
          REG_O_TYPE = 2'($urandom);
          REG_O_ADDR = 4'($urandom);
          RESULT     = 8'($urandom);
          IO_ACK     = (c == k);
          step();
          IO_ACK = 1'b0;
          if (c == k) break;
        end
        if (k > TIMEOUT) merr[0] = 1'b1;
        n_cmp++; if (stb_cycles != ((k > TIMEOUT) ? TIMEOUT : k)) begin
          n_mis++; $display("FAIL rand_io_stb txn %0d got %0d want %0d", n, stb_cycles, (k > TIMEOUT) ? TIMEOUT : k);
        end
      end
      WB_VALID = 1'b0;
      n_cmp++; if (REG_R !== pack_r() || REG_IO !== pack_io() || ERR !== merr || WB_READY !== 1'b1 || IO_STB !== 1'b0) begin
        n_mis++; $display("FAIL rand_state txn %0d got r=%h io=%h err=%b rdy=%b stb=%b want r=%h io=%h err=%b rdy=1 stb=0",
                          n, REG_R, REG_IO, ERR, WB_READY, IO_STB, pack_r(), pack_io(), merr);
      end
    end
  endtask

  initial begin
    RST_WB     = 1'b1;
    WB_VALID   = 1'b0;
    REG_O_TYPE = 2'b00;
    REG_O_ADDR = 4'd0;
    RESULT     = 8'h00;
    IO_ACK     = 1'b0;
    ERR_CLR    = 1'b0;
    model_clear();
    test_reset();
    test_gen_write();
    test_io_ack();
    test_io_timeout();
    test_illegal_discard();
    test_reset_mid_wait();
    test_r0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
